// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a time-multiplexed, active-low 7-segment bus.
// Captures each digit once it has been stable and publishes whole frames.
module seg_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 3,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   digit_dp,
  output logic [NUM_DIGITS-1:0]   digit_ok,
  output logic                    frame_valid,
  output logic                    err
);

  localparam int unsigned InW        = 8 + NUM_DIGITS;
  localparam logic [7:0]  StableMax  = 8'(STABLE_CYCLES);
  localparam logic [7:0]  StableLast = 8'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {StSettle, StLatched} state_e;

  logic [InW-1:0]          live, in_q;
  logic [7:0]              cnt_q, cnt_d;
  state_e                  state_q, state_d;
  logic                    same, capture;

  logic [7:0]              cap_seg;
  logic [NUM_DIGITS-1:0]   cap_sel;
  logic [6:0]              seg_on;
  logic [4:0]              glyph;
  logic                    g_ok;
  logic [3:0]              g_val;
  logic                    sel_blank, sel_one, wr, bad, publish;

  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, digit_val_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_ok_q, digit_dp_q, digit_ok_q;
  logic                    frame_valid_q, err_q;

  // Returns {legal, value}; value is 0 for anything that is not a hex glyph.
  function automatic logic [4:0] glyph_decode(input logic [6:0] s);
    logic [4:0] r;
    r = 5'b0;
    case (s)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h7C: r = {1'b1, 4'hB};
      7'h39: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  assign live = {seg_in, dig_sel};
  assign same = (live == in_q);

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    capture = 1'b0;
    if (!same) begin
      cnt_d = 8'd1;
    end else if (cnt_q < StableMax) begin
      cnt_d = cnt_q + 8'd1;
    end
    unique case (state_q)
      StSettle: begin
        if (same && cnt_q == StableLast) begin
          capture = 1'b1;
          state_d = StLatched;
        end
      end
      StLatched: begin
        if (!same) state_d = StSettle;
      end
      default: state_d = StSettle;
    endcase
  end

  assign cap_seg   = in_q[InW-1 -: 8];
  assign cap_sel   = ~in_q[NUM_DIGITS-1:0];
  assign seg_on    = ~cap_seg[6:0];
  assign glyph     = glyph_decode(seg_on);
  assign g_ok      = glyph[4];
  assign g_val     = glyph[3:0];
  assign sel_blank = (cap_sel == '0);
  assign sel_one   = $onehot(cap_sel);
  assign wr        = capture && sel_one;
  // A dark digit is legitimate blanking; any other unknown pattern is an error.
  assign bad       = capture && !sel_blank && (!sel_one || (!g_ok && seg_on != 7'd0));
  assign publish   = (seen_q == '1);

  always_comb begin
    seen_d = publish ? '0 : seen_q;
    if (wr) seen_d = seen_d | cap_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q          <= '0;
      cnt_q         <= '0;
      state_q       <= StSettle;
      seen_q        <= '0;
      shadow_val_q  <= '0;
      shadow_dp_q   <= '0;
      shadow_ok_q   <= '0;
      digit_val_q   <= '0;
      digit_dp_q    <= '0;
      digit_ok_q    <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      in_q    <= live;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      seen_q  <= seen_d;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (wr && cap_sel[i]) begin
          shadow_val_q[4*i +: 4] <= g_val;
          shadow_ok_q[i]         <= g_ok;
          shadow_dp_q[i]         <= ~cap_seg[7];
        end
      end
      if (publish) begin
        digit_val_q <= shadow_val_q;
        digit_dp_q  <= shadow_dp_q;
        digit_ok_q  <= shadow_ok_q;
      end
      frame_valid_q <= publish;
      err_q         <= bad;
    end
  end

  assign digit_val   = digit_val_q;
  assign digit_dp    = digit_dp_q;
  assign digit_ok    = digit_ok_q;
  assign frame_valid = frame_valid_q;
  assign err         = err_q;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side counterpart of the 7-segment display drivers. Watches a time-multiplexed, active-low segment/digit-select bus and recovers the hex value, decimal point and validity of each digit. Publishes a complete frame once every digit has been captured. Used in benches and on-board loopback to check display output against expected values.

Parameters:
NUM_DIGITS, 3, number of multiplexed digits; 1..8.
STABLE_CYCLES, 4, consecutive identical samples required before a capture; 2..255.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
seg_in  input  8  segment bus, active-low (0 = lit); bit order {dp,g,f,e,d,c,b,a}
dig_sel  input  NUM_DIGITS  digit select, active-low; digit i selected when bit i = 0
digit_val  output  4*NUM_DIGITS  published hex value; digit i in [4i+3:4i]
digit_dp  output  NUM_DIGITS  published decimal point per digit (1 = lit)
digit_ok  output  NUM_DIGITS  1 = published digit held a legal hex glyph
frame_valid  output  1  one-cycle pulse when a new frame is published
err  output  1  one-cycle pulse on an illegal capture

Behaviour:
- Reset: all outputs 0. Input register 0. Stability count 0. Seen-mask 0. Shadow registers 0. FSM in SETTLE.
- Input stage: {seg_in, dig_sel} is registered every edge into in_r. All logic uses in_r and the live input.
- Stability count:
  - If the live input differs from in_r, count <= 1.
  - Otherwise count increments, saturating at STABLE_CYCLES.
- FSM:
  - SETTLE: when count == STABLE_CYCLES-1 and the live input equals in_r, capture in_r on that edge and go to LATCHED. The capture edge is STABLE_CYCLES edges after the first edge that sampled the new value.
  - LATCHED: no further capture. Any input change forces SETTLE with count <= 1.
- Capture rules:
  - dig_sel all ones (blanking): ignored. No write, no err.
  - dig_sel not one-hot-low and not all ones: err pulse, no write.
  - Exactly one digit i selected: decode seg[6:0] (inverted to active-high) to hex 0-F. Standard glyphs: 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D, 0x07, 0x7F, 0x6F, 0x77, 0x7C, 0x39, 0x5E, 0x79, 0x71.
    - Legal glyph: shadow_val[i] <= value, shadow_ok[i] <= 1.
    - All segments off (blank digit): shadow_val[i] <= 0, shadow_ok[i] <= 0, no err.
    - Any other pattern: shadow_val[i] <= 0, shadow_ok[i] <= 0, err pulse.
    - In all three cases: shadow_dp[i] <= ~seg[7], and seen[i] <= 1.
- Re-capture of a digit before the frame completes overwrites its shadow. The seen-mask is unchanged.
- Frame publish: on the edge after the capture that makes seen all ones:
  - digit_val, digit_dp, digit_ok <= shadow.
  - frame_valid = 1 for exactly one cycle.
  - seen <= 0.
  - Outputs hold between frames.
- A capture on the same edge as a publish counts toward the next frame.
- Glitches shorter than STABLE_CYCLES samples never cause a capture.
- rst mid-operation: everything returns to reset values on that edge. Partially collected frames are discarded.

Test Plan:
1. NUM_DIGITS=3, STABLE_CYCLES=4. Drive digit0 = 0xF9, digit1 = 0xA4, digit2 = 0xB0, each held 6 cycles -> frame_valid single pulse; digit_val = 12'h321, digit_ok = 3'b111, digit_dp = 0, err never set.
2. Digit held exactly 3 cycles (below STABLE_CYCLES) between valid digits -> no capture. The frame completes only after that digit is held 4 or more cycles; frame_valid appears 4 edges plus 1 after its first sample.
3. seg_in = 0xFE (only segment a lit) on digit1 -> err pulses once; after completion digit_ok = 3'b101 and digit1 value = 0. seg_in = 0xFF -> no err, digit_ok bit 0.
4. dig_sel = 3'b100 (two digits low) held 5 cycles -> err pulse, seen-mask unchanged, no frame. dig_sel = 3'b111 -> no err, no capture.
5. seg_in = 0x08 (A with dp) on digit2 -> digit_val[11:8] = 4'hA, digit_dp[2] = 1. Re-drive digit0 = 0xC0 then 0x80 before the frame completes -> published digit0 = 8.
6. rst asserted one cycle after two of three digits are captured -> all outputs 0, no frame_valid until all three digits are re-captured.
